// File: rtl/mem_stage_resp_if.sv
// Command/response bundle between the memory-stage control and the data RAM responder.
interface mem_stage_resp_if;
    logic        Req;
    logic        We;
    logic        Byte_Sel;
    logic [31:0] Addr;
    logic [31:0] Wdata;
    logic        Busy;
    logic        Ack;
    logic        Err;
    logic [31:0] Rdata;

    modport master (
        output Req, We, Byte_Sel, Addr, Wdata,
        input  Busy, Ack, Err, Rdata
    );

    modport slave (
        input  Req, We, Byte_Sel, Addr, Wdata,
        output Busy, Ack, Err, Rdata
    );
endinterface

// File: rtl/mem_stage_resp.sv
// Memory-stage responder: data RAM with word/byte reads and read-modify-write byte writes.
// Build option MEM_LB_SIGN_EXT_EN: byte reads sign-extend from bit 7 (default zero-extend).
module mem_stage_resp #(
    parameter int ADDR_W = 10
) (
    input  logic            Clk,
    input  logic            Reset_n,
    mem_stage_resp_if.slave bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, READ, MERGE, RESP} state_t;

    state_t            state_q, state_d;
    logic              busy_q, busy_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              bsel_q, bsel_d;
    logic              cerr_q, cerr_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [1:0]        lane_q, lane_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       word_q, word_d;
    logic              mem_we;
    logic [31:0]       mem_wdata;
    logic              cmd_err;
    logic [31:0]       mem_q [DEPTH];

    function automatic logic [31:0] ext_byte(input logic [31:0] w, input logic [1:0] lane);
        logic [7:0] b;
        b = w[{lane, 3'b000} +: 8];
`ifdef MEM_LB_SIGN_EXT_EN
        return {{24{b[7]}}, b};
`else
        return {24'd0, b};
`endif
    endfunction

    function automatic logic [31:0] merge_byte(input logic [31:0] w, input logic [1:0] lane,
                                               input logic [7:0] b);
        logic [31:0] m;
        m = w;
        m[{lane, 3'b000} +: 8] = b;
        return m;
    endfunction

    // Out-of-range upper address bits, or a word access that is not 4-byte aligned.
    assign cmd_err = ((bus.Addr >> (ADDR_W + 2)) != 32'd0) ||
                     (!bus.Byte_Sel && (bus.Addr[1:0] != 2'b00));

    always_comb begin
        state_d   = state_q;
        busy_d    = busy_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        rdata_d   = rdata_q;
        we_d      = we_q;
        bsel_d    = bsel_q;
        cerr_d    = cerr_q;
        idx_d     = idx_q;
        lane_d    = lane_q;
        wdata_d   = wdata_q;
        word_d    = word_q;
        mem_we    = 1'b0;
        mem_wdata = wdata_q;
        case (state_q)
            IDLE: begin
                if (bus.Req) begin
                    busy_d  = 1'b1;
                    we_d    = bus.We;
                    bsel_d  = bus.Byte_Sel;
                    cerr_d  = cmd_err;
                    idx_d   = bus.Addr[ADDR_W+1:2];
                    lane_d  = bus.Addr[1:0];
                    wdata_d = bus.Wdata;
                    if (cmd_err || (bus.We && !bus.Byte_Sel))
                        state_d = RESP;
                    else
                        state_d = READ;
                end
            end
            READ: begin
                // Only reads and byte writes pass through here; a write here needs the merge.
                word_d  = mem_q[idx_q];
                state_d = we_q ? MERGE : RESP;
            end
            MERGE: begin
                mem_we    = 1'b1;
                mem_wdata = merge_byte(word_q, lane_q, wdata_q[7:0]);
                ack_d     = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            RESP: begin
                ack_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
                if (cerr_q) begin
                    err_d = 1'b1;
                    if (!we_q)
                        rdata_d = 32'd0;
                end else if (we_q) begin
                    mem_we = 1'b1;
                end else begin
                    rdata_d = bsel_q ? ext_byte(word_q, lane_q) : word_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'd0;
            we_q    <= 1'b0;
            bsel_q  <= 1'b0;
            cerr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            we_q    <= we_d;
            bsel_q  <= bsel_d;
            cerr_q  <= cerr_d;
        end
    end

    // Datapath and array are left out of reset; reset clears the state so a pending write is dropped.
    always_ff @(posedge Clk) begin
        idx_q   <= idx_d;
        lane_q  <= lane_d;
        wdata_q <= wdata_d;
        word_q  <= word_d;
        if (mem_we)
            mem_q[idx_q] <= mem_wdata;
    end

    assign bus.Busy  = busy_q;
    assign bus.Ack   = ack_q;
    assign bus.Err   = err_q;
    assign bus.Rdata = rdata_q;
endmodule

// File: tb/tb_mem_stage_resp.sv
// Self-checking bench for mem_stage_resp: command table with a response scoreboard plus handshake/reset sequences.
module tb_mem_stage_resp;
    localparam int ADDR_W = 10;

    logic Clk = 1'b0;
    logic Reset_n;

    mem_stage_resp_if bus ();

    mem_stage_resp #(.ADDR_W(ADDR_W)) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        we;
        logic        bsel;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_err;
        logic [31:0] exp_rdata;
        int          exp_lat;
    } vec_t;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[24];
    int   errors = 0;
    int   checks = 0;

    function automatic logic [31:0] lb(input logic [7:0] b);
`ifdef MEM_LB_SIGN_EXT_EN
        return {{24{b[7]}}, b};
`else
        return {24'd0, b};
`endif
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic err, input logic [31:0] rdata, input int lat);
        exp_t e;
        e.err   = err;
        e.rdata = rdata;
        e.lat   = lat;
        sb_q.push_back(e);
    endtask

    // Called at the negedge after the accepting edge; returns at the negedge inside the Ack cycle.
    task automatic wait_resp(input string name);
        exp_t e;
        int   lat;
        bit   got;
        lat = 0;
        got = 1'b0;
        while (lat < 20 && !got) begin
            @(posedge Clk);
            lat++;
            @(negedge Clk);
            if (bus.Ack === 1'b1) got = 1'b1;
        end
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s_scoreboard: response with no expected entry", name);
            return;
        end
        e = sb_q.pop_front();
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no Ack within %0d edges, required %0d", name, lat, e.lat);
            return;
        end
        check32({name, "_lat"},   lat,       e.lat);
        check32({name, "_err"},   bus.Err,   {31'd0, e.err});
        check32({name, "_rdata"}, bus.Rdata, e.rdata);
        check32({name, "_busy_at_ack"}, {31'd0, bus.Busy}, 32'd0);
    endtask

    task automatic run_cmd(input string name, input vec_t v);
        @(negedge Clk);
        bus.Req      = 1'b1;
        bus.We       = v.we;
        bus.Byte_Sel = v.bsel;
        bus.Addr     = v.addr;
        bus.Wdata    = v.wdata;
        push_exp(v.exp_err, v.exp_rdata, v.exp_lat);
        @(posedge Clk);
        @(negedge Clk);
        bus.Req      = 1'b0;
        bus.We       = ~v.we;
        bus.Byte_Sel = ~v.bsel;
        bus.Addr     = ~v.addr;
        bus.Wdata    = ~v.wdata;
        check32({name, "_busy"}, {31'd0, bus.Busy}, 32'd1);
        wait_resp(name);
        @(negedge Clk);
        check32({name, "_ack_pulse"}, {31'd0, bus.Ack}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t rv;
        tbl[0]  = '{1'b1, 1'b0, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 1};
        tbl[1]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 2};
        tbl[2]  = '{1'b1, 1'b1, 32'h0000_0012, 32'h0000_00A5, 1'b0, 32'hDEAD_BEEF, 2};
        tbl[3]  = '{1'b0, 1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEA5_BEEF, 2};
        tbl[4]  = '{1'b0, 1'b1, 32'h0000_0013, 32'h0,         1'b0, lb(8'hDE),     2};
        tbl[5]  = '{1'b0, 1'b1, 32'h0000_0011, 32'h0,         1'b0, lb(8'hBE),     2};
        tbl[6]  = '{1'b0, 1'b1, 32'h0000_0010, 32'h0,         1'b0, lb(8'hEF),     2};
        tbl[7]  = '{1'b0, 1'b1, 32'h0000_0012, 32'h0,         1'b0, lb(8'hA5),     2};
        tbl[8]  = '{1'b0, 1'b0, 32'h0000_0011, 32'h0,         1'b1, 32'h0000_0000, 1};
        tbl[9]  = '{1'b1, 1'b0, 32'h0000_0000, 32'h1234_5678, 1'b0, 32'h0000_0000, 1};
        tbl[10] = '{1'b1, 1'b0, 32'h0000_1000, 32'hCAFE_F00D, 1'b1, 32'h0000_0000, 1};
        tbl[11] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678, 2};
        tbl[12] = '{1'b1, 1'b0, 32'h0000_0002, 32'hFFFF_FFFF, 1'b1, 32'h1234_5678, 1};
        tbl[13] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678, 2};
        tbl[14] = '{1'b1, 1'b1, 32'h0000_1003, 32'h0000_0077, 1'b1, 32'h1234_5678, 1};
        tbl[15] = '{1'b0, 1'b1, 32'h8000_0000, 32'h0,         1'b1, 32'h0000_0000, 1};
        tbl[16] = '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0BAD_F00D, 1'b0, 32'h0000_0000, 1};
        tbl[17] = '{1'b0, 1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'h0BAD_F00D, 2};
        tbl[18] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h1234_5678, 2};
        tbl[19] = '{1'b1, 1'b0, 32'h0000_0020, 32'h1122_3344, 1'b0, 32'h1234_5678, 1};
        tbl[20] = '{1'b0, 1'b1, 32'h0000_0FFF, 32'h0,         1'b0, lb(8'h0B),     2};
        tbl[21] = '{1'b1, 1'b1, 32'h0000_0FFC, 32'h0000_0080, 1'b0, lb(8'h0B),     2};
        tbl[22] = '{1'b0, 1'b0, 32'h0000_0FFC, 32'h0,         1'b0, 32'h0BAD_F080, 2};
        tbl[23] = '{1'b0, 1'b1, 32'h0000_0FFC, 32'h0,         1'b0, lb(8'h80),     2};

        Reset_n      = 1'b0;
        bus.Req      = 1'b0;
        bus.We       = 1'b0;
        bus.Byte_Sel = 1'b0;
        bus.Addr     = 32'd0;
        bus.Wdata    = 32'd0;
        #12;
        check32("rst_busy",  {31'd0, bus.Busy}, 32'd0);
        check32("rst_ack",   {31'd0, bus.Ack},  32'd0);
        check32("rst_err",   {31'd0, bus.Err},  32'd0);
        check32("rst_rdata", bus.Rdata,         32'd0);
        @(negedge Clk);
        Reset_n = 1'b1;

        for (int i = 0; i < 24; i++)
            run_cmd($sformatf("v%0d", i), tbl[i]);

        // Req held high across two reads; Addr changes while the first is in flight.
        @(negedge Clk);
        bus.Req      = 1'b1;
        bus.We       = 1'b0;
        bus.Byte_Sel = 1'b0;
        bus.Addr     = 32'h0000_0010;
        push_exp(1'b0, 32'hDEA5_BEEF, 2);
        push_exp(1'b0, 32'h1234_5678, 2);
        @(posedge Clk);
        @(negedge Clk);
        bus.Addr = 32'h0000_0000;
        check32("b2b_first_busy", {31'd0, bus.Busy}, 32'd1);
        wait_resp("b2b_first");
        @(posedge Clk);
        @(negedge Clk);
        bus.Req = 1'b0;
        check32("b2b_second_busy", {31'd0, bus.Busy}, 32'd1);
        wait_resp("b2b_second");
        @(negedge Clk);
        check32("b2b_ack_pulse", {31'd0, bus.Ack}, 32'd0);

        // Reset while a byte write to word 0x20 sits in MERGE.
        @(negedge Clk);
        bus.Req      = 1'b1;
        bus.We       = 1'b1;
        bus.Byte_Sel = 1'b1;
        bus.Addr     = 32'h0000_0020;
        bus.Wdata    = 32'h0000_00FF;
        @(posedge Clk);
        @(negedge Clk);
        bus.Req = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        check32("midrst_busy",  {31'd0, bus.Busy}, 32'd0);
        check32("midrst_ack",   {31'd0, bus.Ack},  32'd0);
        check32("midrst_err",   {31'd0, bus.Err},  32'd0);
        check32("midrst_rdata", bus.Rdata,         32'd0);
        @(posedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
        rv = '{1'b0, 1'b0, 32'h0000_0020, 32'h0, 1'b0, 32'h1122_3344, 2};
        run_cmd("post_rst_read", rv);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
